key_event_tracker: RTL

KEY_EVENT_TRACKER -- requirements
Module: key_event_tracker

---
 rtl/key_event_tracker.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/key_event_tracker.sv
// key_event_tracker
//
// Decodes PS/2 set-2 scan bytes into a held-key bitmap for a configurable set
// of keys and queues press/release edges in a first-word-fall-through FIFO.
//
// Ports
//   clock          sole clock, rising edge
//   resetn         asynchronous active-low reset
//   rx_data        scan byte from the PS/2 controller
//   rx_valid       one-cycle strobe qualifying rx_data
//   keys           held-key bitmap, bit i = key i down
//   evt_key        key index of the head event (zero when the FIFO is empty)
//   evt_make       head event type, 1 = press, 0 = release
//   evt_valid      FIFO non-empty
//   evt_ready      consumer pop request
//   overflow       sticky: an event was dropped because the FIFO was full
//   clear_overflow synchronous clear of overflow (a coincident drop wins)
//   prefix_state   debug view of the prefix decoder state
//
// Event handshake: the head entry is presented whenever evt_valid is high and
// stays stable until it is taken; an entry is taken on a rising edge where
// evt_valid and evt_ready are both high. evt_ready may be held high freely.

module key_event_tracker #(
    parameter int NUM_KEYS   = 16,
    parameter int FIFO_DEPTH = 8,
    // Entry i = {ext, code[7:0]} in bits [9i+8:9i]; entry 0 is the rightmost.
    parameter logic [9*NUM_KEYS-1:0] KEY_CODES = {
        9'h00D, 9'h111, 9'h011, 9'h114, 9'h014, 9'h012, 9'h076, 9'h05A,
        9'h029, 9'h174, 9'h16B, 9'h172, 9'h175, 9'h023, 9'h01B, 9'h01C
    }
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [NUM_KEYS-1:0] keys,
    output logic [5:0]          evt_key,
    output logic                evt_make,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic                overflow,
    input  logic                clear_overflow,
    output logic [1:0]          prefix_state
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GOT_E0   = 2'd1,
        GOT_F0   = 2'd2,
        GOT_E0F0 = 2'd3
    } state_t;

    state_t state, state_next;

    logic [NUM_KEYS-1:0] keys_next;
    logic [NUM_KEYS-1:0] hit_mask;
    logic [5:0]          hit_idx;
    logic                hit;
    logic                was_down;
    logic [8:0]          lookup_code;
    logic                is_ext;
    logic                is_brk;
    logic                push;
    logic                push_make;

    logic [5:0]  fifo_key  [FIFO_DEPTH];
    logic        fifo_make [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          full, pop, push_ok, drop;

    assign prefix_state = state;

    assign is_ext      = (state == GOT_E0) || (state == GOT_E0F0);
    assign is_brk      = (state == GOT_F0) || (state == GOT_E0F0);
    assign lookup_code = {is_ext, rx_data};

    // Scan downwards so the last match written is the lowest index.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_mask = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (KEY_CODES[9*i +: 9] == lookup_code) begin
                hit         = 1'b1;
                hit_idx     = 6'(i);
                hit_mask    = '0;
                hit_mask[i] = 1'b1;
            end
        end
    end

    assign was_down = |(keys & hit_mask);

    // Prefix decoder and key bitmap update.
    always_comb begin
        state_next = state;
        keys_next  = keys;
        push       = 1'b0;
        push_make  = 1'b0;
        if (rx_valid) begin
            if (rx_data == 8'h00 || rx_data == 8'hFF) begin
                // Controller error / buffer overrun: forget everything held.
                state_next = IDLE;
                keys_next  = '0;
            end else if (rx_data == 8'hE0) begin
                state_next = GOT_E0;
            end else if (rx_data == 8'hF0) begin
                state_next = (state == GOT_E0) ? GOT_E0F0 : GOT_F0;
            end else begin
                state_next = IDLE;
                if (hit) begin
                    if (is_brk) begin
                        keys_next = keys & ~hit_mask;
                        push      = was_down;
                        push_make = 1'b0;
                    end else begin
                        // Typematic repeats of a held key produce no event.
                        keys_next = keys | hit_mask;
                        push      = ~was_down;
                        push_make = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            keys  <= '0;
        end else begin
            state <= state_next;
            keys  <= keys_next;
        end
    end

    // Event FIFO. A pop frees a slot in the same cycle, so a full FIFO still
    // accepts a push when the head is being taken.
    assign evt_valid = (count != '0);
    assign full      = (count == DEPTH_C);
    assign pop       = evt_valid & evt_ready;
    assign push_ok   = push & (~full | pop);
    assign drop      = push & full & ~pop;

    assign evt_key  = evt_valid ? fifo_key[rd_ptr]  : 6'd0;
    assign evt_make = evt_valid ? fifo_make[rd_ptr] : 1'b0;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_key[wr_ptr]  <= hit_idx;
            fifo_make[wr_ptr] <= push_make;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
            if (drop)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
        end
    end

endmodule
